// File: rtl/pam4_prbs_upsampler.sv
// rtl/pam4_prbs_upsampler.sv - PRBS PAM4 symbol source, Gray-mapped and zero-stuffed to OSR samples per symbol
// Optional impulse-capture mode is enabled with `define MAPPER_IMPULSE_EN.
module pam4_prbs_upsampler #(
    parameter int                        WIDTH  = 18,
    parameter int                        OSR    = 4,
    parameter int                        LFSR_W = 15,
    parameter logic [LFSR_W-1:0]         SEED   = LFSR_W'(1),
    parameter logic signed [WIDTH-1:0]   LVL_A  = WIDTH'(32'sd32768),
    parameter logic signed [WIDTH-1:0]   LVL_3A = WIDTH'(32'sd98303)
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    sam_clk_en,
`ifdef MAPPER_IMPULSE_EN
    input  logic                    impulse_mode,
`endif
    output logic signed [WIDTH-1:0] x_out,
    output logic                    sym_clk_en,
    output logic [1:0]              sym_bits
);

    localparam int              PH_W    = $clog2(OSR);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

    logic [PH_W-1:0]         ph_q, ph_d;
    logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic                    sym_q, sym_d;
    logic [1:0]              bits_q, bits_d;

    logic sym_sample;
    logic impulse_now;
    logic impulse_hit;

    assign sym_sample = sam_clk_en && (ph_q == '0);

`ifdef MAPPER_IMPULSE_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sym_sample) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign impulse_now = impulse_mode;
    assign impulse_hit = (cnt_q == 8'd0);
`else
    assign impulse_now = 1'b0;
    assign impulse_hit = 1'b0;
`endif

    // Fibonacci LFSR, polynomial x^15 + x^14 + 1
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_W-1] ^ s[LFSR_W-2]};
    endfunction

    function automatic logic signed [WIDTH-1:0] gray_map(input logic [1:0] b);
        case (b)
            2'b00:   return -LVL_3A;
            2'b01:   return -LVL_A;
            2'b11:   return LVL_A;
            default: return LVL_3A;
        endcase
    endfunction

    always_comb begin
        ph_d   = ph_q;
        lfsr_d = lfsr_q;
        x_d    = x_q;
        bits_d = bits_q;
        sym_d  = 1'b0;
        if (sam_clk_en) begin
            ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
            if (sym_sample) begin
                sym_d = 1'b1;
                if (impulse_now) begin
                    x_d    = impulse_hit ? LVL_3A : '0;
                    bits_d = impulse_hit ? 2'b10 : 2'b00;
                end else begin
                    bits_d = lfsr_q[1:0];
                    x_d    = gray_map(lfsr_q[1:0]);
                    // All-zero is the LFSR lock-up state; recover by reloading the seed
                    lfsr_d = (lfsr_q == '0) ? SEED : lfsr_step(lfsr_step(lfsr_q));
                end
            end else begin
                x_d = '0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            ph_q   <= '0;
            lfsr_q <= SEED;
            x_q    <= '0;
            sym_q  <= 1'b0;
            bits_q <= 2'b00;
        end else begin
            ph_q   <= ph_d;
            lfsr_q <= lfsr_d;
            x_q    <= x_d;
            sym_q  <= sym_d;
            bits_q <= bits_d;
        end
    end

    assign x_out      = x_q;
    assign sym_clk_en = sym_q;
    assign sym_bits   = bits_q;

endmodule

// File: tb/tb_pam4_prbs_upsampler.sv
// tb/tb_pam4_prbs_upsampler.sv - directed self-checking bench for pam4_prbs_upsampler
module tb_pam4_prbs_upsampler;

    logic               sys_clk = 1'b0;
    logic               reset_n;
    logic               sam_clk_en;
`ifdef MAPPER_IMPULSE_EN
    logic               impulse_mode;
`endif
    logic signed [17:0] x_out;
    logic               sym_clk_en;
    logic [1:0]         sym_bits;

    int tests = 0;
    int fails = 0;

    logic [14:0] m_lfsr;
    int          m_ph;
    logic [1:0]  m_bits;

    pam4_prbs_upsampler dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .sam_clk_en  (sam_clk_en),
`ifdef MAPPER_IMPULSE_EN
        .impulse_mode(impulse_mode),
`endif
        .x_out       (x_out),
        .sym_clk_en  (sym_clk_en),
        .sym_bits    (sym_bits)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst_n, input logic sam);
        reset_n    = rst_n;
        sam_clk_en = sam;
        @(negedge sys_clk);
    endtask

    function automatic logic [14:0] m_step(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    function automatic int m_map(input logic [1:0] b);
        case (b)
            2'b00:   return -98303;
            2'b01:   return -32768;
            2'b11:   return 32768;
            default: return 98303;
        endcase
    endfunction

    task automatic model_reset();
        m_lfsr = 15'h0001;
        m_ph   = 0;
        m_bits = 2'b00;
    endtask

    task automatic model_sample(output int ex, output logic es);
        if (m_ph == 0) begin
            m_bits = m_lfsr[1:0];
            ex     = m_map(m_bits);
            es     = 1'b1;
            m_lfsr = (m_lfsr == 15'd0) ? 15'h0001 : m_step(m_step(m_lfsr));
        end else begin
            ex = 0;
            es = 1'b0;
        end
        m_ph = (m_ph + 1) % 4;
    endtask

    initial begin
        int dir_x [8];
        int ex;
        logic es;
        int zeros;
        int dut_hist [4];
        int m_hist [4];

        dir_x = '{-32768, 0, 0, 0, -98303, 0, 0, 0};
`ifdef MAPPER_IMPULSE_EN
        impulse_mode = 1'b0;
`endif

        // Reset wins over a simultaneous strobe
        reset_n    = 1'b0;
        sam_clk_en = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("rst_x", x_out, 0);
        check("rst_sym", sym_clk_en, 0);
        check("rst_bits", sym_bits, 0);

        // Eight strobes, one per four cycles
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1);
            check($sformatf("dir_x%0d", i), x_out, dir_x[i]);
            check($sformatf("dir_sym%0d", i), sym_clk_en, (i % 4 == 0) ? 1 : 0);
            if (i == 0) check("dir_bits0", sym_bits, 1);
            if (i == 4) check("dir_bits4", sym_bits, 0);
            cyc(1'b1, 1'b0);
            check($sformatf("dir_sym_drop%0d", i), sym_clk_en, 0);
            check($sformatf("dir_hold%0d", i), x_out, dir_x[i]);
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b0);
        end

        // Third symbol, then 20 idle cycles: outputs must freeze
        cyc(1'b1, 1'b1);
        check("sym3_x", x_out, -98303);
        check("sym3_sym", sym_clk_en, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0);
            check($sformatf("frz_x%0d", i), x_out, -98303);
            check($sformatf("frz_sym%0d", i), sym_clk_en, 0);
            check($sformatf("frz_bits%0d", i), sym_bits, 0);
        end
        cyc(1'b1, 1'b1);
        check("after_frz_x", x_out, 0);

        // Back-to-back strobes against the reference LFSR model
        cyc(1'b0, 1'b0);
        model_reset();
        zeros = 0;
        for (int k = 0; k < 4; k++) begin
            dut_hist[k] = 0;
            m_hist[k]   = 0;
        end
        for (int i = 0; i < 400; i++) begin
            cyc(1'b1, 1'b1);
            model_sample(ex, es);
            check($sformatf("b2b_x%0d", i), x_out, ex);
            check($sformatf("b2b_sym%0d", i), sym_clk_en, es);
            check($sformatf("b2b_bits%0d", i), sym_bits, m_bits);
            if (i == 32) check("b2b_sym8_outer", x_out, 98303);
            if (x_out == 0) zeros++;
            if (sym_clk_en) dut_hist[sym_bits]++;
            if (es) m_hist[m_bits]++;
        end
        check("b2b_zeros", zeros, 300);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("hist%0d", k), dut_hist[k], m_hist[k]);
        end
        check("hist_total", dut_hist[0] + dut_hist[1] + dut_hist[2] + dut_hist[3], 100);

        // Reset with a strobe at symbol 10 restarts from the seed
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        check("mid_rst_x", x_out, 0);
        check("mid_rst_sym", sym_clk_en, 0);
        check("mid_rst_bits", sym_bits, 0);
        cyc(1'b1, 1'b1);
        check("restart_x0", x_out, -32768);
        check("restart_sym0", sym_clk_en, 1);
        check("restart_bits0", sym_bits, 1);
        cyc(1'b1, 1'b1);
        check("restart_x1", x_out, 0);
        check("restart_bits1", sym_bits, 1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check("restart_x4", x_out, -98303);
        check("restart_bits4", sym_bits, 0);

`ifdef MAPPER_IMPULSE_EN
        impulse_mode = 1'b1;
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 2100; i++) begin
            cyc(1'b1, 1'b1);
            check($sformatf("imp_x%0d", i), x_out, (i % 1024 == 0) ? 98303 : 0);
            check($sformatf("imp_bits%0d", i), sym_bits, ((i / 4) % 256 == 0) ? 2 : 0);
        end
        impulse_mode = 1'b0;
        cyc(1'b1, 1'b1);
        check("imp_resume_x", x_out, -32768);
        check("imp_resume_bits", sym_bits, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pam4_prbs_upsampler.md
# pam4_prbs_upsampler

Upstream source stage for the 101-tap symmetric pulse-shaping filter. Generates a pseudo-random 4-level PAM symbol stream from an internal LFSR and Gray-maps it to 1s17 amplitudes. Zero-stuffs to 4 samples per symbol, so the filter's `x_in` receives one impulse per symbol period. Runs on `sys_clk`, advances only on `sam_clk_en`, and exports a symbol strobe for downstream timing.

## Interface
- `WIDTH`, 18: output sample width, signed 1s17.
- `OSR`, 4: samples per symbol; must be ≥2.
- `LFSR_W`, 15: LFSR length. Fixed polynomial x^15+x^14+1.
- `SEED`, 15'h0001: LFSR reset/reload value; must be non-zero.
- `LVL_A`, 18'sd32768: inner level (0.25).
- `LVL_3A`, 18'sd98303: outer level (≈0.75).
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `sam_clk_en`  in  1  one-cycle sample strobe; all state advances only when high.
- `x_out`  out  WIDTH  signed 1s17 upsampled symbol sample; connects to filter `x_in`.
- `sym_clk_en`  out  1  one-cycle pulse marking the sample that carries a symbol.
- `sym_bits`  out  2  raw symbol bits carried by the current symbol; for the checker.
- `impulse_mode`  in  1  present only with `MAPPER_IMPULSE_EN`; see Configuration.

## Operation
- Phase counter `ph` counts 0..OSR-1 and increments mod OSR on each `sam_clk_en`.
- On `sam_clk_en` with `ph==0` (symbol sample):
  - `sym_bits <= lfsr[1:0]`.
  - `x_out <= map(lfsr[1:0])`.
  - LFSR advances two single steps. One step: `fb = s[14]^s[13]`; `s <= {s[13:0], fb}`.
  - `sym_clk_en <= 1`.
- On `sam_clk_en` with `ph!=0`:
  - `x_out <= 0` (zero insertion).
  - `sym_clk_en <= 0`.
  - `sym_bits` and the LFSR hold.
- Without `sam_clk_en`: all registers hold, except `sym_clk_en`, which is forced to 0.
- Gray map: 00→-`LVL_3A`, 01→-`LVL_A`, 11→+`LVL_A`, 10→+`LVL_3A`.
  - Max magnitude 98303 < 2^17, so no saturation logic is needed.
  - The filter's internal 1-bit right shift keeps its summation headroom.
- Lock-up guard: if the LFSR is ever all-zero at a symbol sample, reload `SEED` instead of stepping. `x_out` for that symbol is still map(00).

## Timing
- Reset (`reset_n==0` at an edge) sets:
  - `x_out=0`, `sym_clk_en=0`, `sym_bits=2'b00`
  - `ph=0`, `lfsr=SEED`, impulse counter = 0
- Reset has priority over a simultaneous `sam_clk_en`.
- A reset mid-stream restarts the sequence bit-identically from `SEED`.
- Latency: `x_out` and `sym_clk_en` are registered and update on the same edge as the `sam_clk_en` that caused them. `sym_clk_en` is high for exactly one `sys_clk` cycle.
- The first `sam_clk_en` after reset is a symbol sample (`ph==0`).
- Back-to-back `sam_clk_en` (every cycle) is legal; throughput is one sample per strobe.
- Sequence period: (2^15-1) LFSR states. At two steps per symbol, the symbol sequence repeats every 32767 symbols (2 is coprime to 32767).

## Configuration
- `MAPPER_IMPULSE_EN` defined:
  - Adds the `impulse_mode` port and an 8-bit symbol counter that increments on each symbol sample and resets to 0.
  - While `impulse_mode==1`: the symbol sample outputs +`LVL_3A` when the counter is 0, else 0. The LFSR is frozen, and `sym_bits` shows 2'b10 on the impulse and 2'b00 otherwise.
  - This yields one impulse every 256 symbols (1024 samples), longer than the 101-tap response, for filter impulse-response capture.
  - Deasserting `impulse_mode` resumes the PRBS from the frozen LFSR state.
- `MAPPER_IMPULSE_EN` undefined: port and counter are absent; the output is always PRBS.

## Test plan
- Reset, then 8 strobes at 1 per 4 cycles → `x_out` = -32768, 0, 0, 0, -98303, 0, 0, 0. `sym_clk_en` high only on strobes 1 and 5; `sym_bits` = 01 then 00.
- Hold `sam_clk_en=0` for 20 cycles mid-stream → all outputs frozen; `sym_clk_en` stays 0.
- Run 32767×4 strobes → the symbol sequence repeats exactly at symbol 32768. Compare against a reference LFSR model, including the histogram of `sym_bits` values.
- Assert `reset_n=0` simultaneously with `sam_clk_en` at symbol 10 → the next outputs equal the first post-reset sequence (-32768, ...).
- `sam_clk_en` every cycle → `sym_clk_en` has period 4 and `x_out` is zero at 3 of every 4 samples.
- With `MAPPER_IMPULSE_EN`, `impulse_mode=1` from reset → `x_out` is 98303 at samples 0, 1024, 2048 and 0 elsewhere. Drop `impulse_mode` → the PRBS resumes from the frozen state.
